// File: rtl/req_arbiter_8_if.sv
// -----------------------------------------------------------------------------
// req_arbiter_8_if
// Request/grant bundle between request sources, the round-robin arbiter and
// the downstream 8-to-3 encoder.
//   req_in       : request pulses, bit i requests source i
//   enable       : permits new grants (never aborts a grant in progress)
//   grant_ready  : downstream accepts the current grant
//   grant_onehot : one-hot grant feeding encoder_in, zero when not valid
//   grant_valid  : grant_onehot holds a valid grant
//   pending      : latched outstanding requests
//   grant_count  : accepted grants, modulo 2^COUNT_W
// Modports: master = arbiter side, slave = requester/consumer side.
// -----------------------------------------------------------------------------
interface req_arbiter_8_if #(
  parameter int COUNT_W = 8
);
  logic [7:0]         req_in;
  logic               enable;
  logic               grant_ready;
  logic [7:0]         grant_onehot;
  logic               grant_valid;
  logic [7:0]         pending;
  logic [COUNT_W-1:0] grant_count;

  modport master (
    input  req_in,
    input  enable,
    input  grant_ready,
    output grant_onehot,
    output grant_valid,
    output pending,
    output grant_count
  );

  modport slave (
    output req_in,
    output enable,
    output grant_ready,
    input  grant_onehot,
    input  grant_valid,
    input  pending,
    input  grant_count
  );
endinterface

// File: rtl/req_arbiter_8.sv
// -----------------------------------------------------------------------------
// req_arbiter_8
// Upstream stage of the 8-to-3 encoder. Latches request pulses into a pending
// vector and issues one-hot grants round-robin; each grant drives encoder_in.
// Ports:
//   clk   : rising-edge clock for all state
//   reset : synchronous, active-high reset
//   bus   : req_arbiter_8_if.master (req_in, enable, grant_ready in;
//           grant_onehot, grant_valid, pending, grant_count out)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module req_arbiter_8 #(
  parameter int COUNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  req_arbiter_8_if.master  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_r,        state_nxt_s;
  logic [7:0]         pending_r,      pending_nxt_s;
  logic [7:0]         grant_onehot_r, grant_onehot_nxt_s;
  logic               grant_valid_r,  grant_valid_nxt_s;
  logic [2:0]         grant_idx_r,    grant_idx_nxt_s;
  logic [2:0]         last_ptr_r,     last_ptr_nxt_s;
  logic [COUNT_W-1:0] grant_count_r,  grant_count_nxt_s;

  logic               accept_s;
  logic [7:0]         clear_mask_s;
  logic [7:0]         cand_s;
  logic [2:0]         pick_idle_s;
  logic [2:0]         pick_next_s;

  // First set bit of vec searched upward from ptr+1, wrapping 7 -> 0; the
  // last position examined is ptr itself.
  function automatic logic [2:0] rr_pick(input logic [7:0] vec, input logic [2:0] ptr);
    logic [2:0] idx;
    logic [2:0] sel;
    logic       hit;
    sel = ptr;
    hit = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr + 3'(k);
      if (!hit && vec[idx]) begin
        sel = idx;
        hit = 1'b1;
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  // Acceptance, pending update and next-winner candidates.
  always_comb begin
    accept_s     = grant_valid_r & bus.grant_ready;
    clear_mask_s = accept_s ? grant_onehot_r : 8'h00;
    // A request on the accepting edge beats the clear.
    pending_nxt_s = (pending_r & ~clear_mask_s) | bus.req_in;
    // Back-to-back candidates: everything still pending except the bit being
    // accepted, unless that same bit is re-requested on this edge.
    cand_s      = (pending_r & ~grant_onehot_r) | (bus.req_in & grant_onehot_r);
    pick_idle_s = rr_pick(pending_r, last_ptr_r);
    pick_next_s = rr_pick(cand_s, grant_idx_r);
  end

  // FSM next-state and grant/counter next values.
  always_comb begin
    state_nxt_s        = state_r;
    grant_onehot_nxt_s = grant_onehot_r;
    grant_valid_nxt_s  = grant_valid_r;
    grant_idx_nxt_s    = grant_idx_r;
    last_ptr_nxt_s     = last_ptr_r;
    grant_count_nxt_s  = grant_count_r;
    case (state_r)
      IDLE: begin
        if (bus.enable && (pending_r != 8'h00)) begin
          state_nxt_s        = GRANT;
          grant_onehot_nxt_s = 8'b0000_0001 << pick_idle_s;
          grant_valid_nxt_s  = 1'b1;
          grant_idx_nxt_s    = pick_idle_s;
        end else begin
          grant_onehot_nxt_s = 8'h00;
          grant_valid_nxt_s  = 1'b0;
        end
      end
      GRANT: begin
        if (accept_s) begin
          last_ptr_nxt_s    = grant_idx_r;
          grant_count_nxt_s = grant_count_r + COUNT_W'(1);
          if (bus.enable && (cand_s != 8'h00)) begin
            state_nxt_s        = GRANT;
            grant_onehot_nxt_s = 8'b0000_0001 << pick_next_s;
            grant_valid_nxt_s  = 1'b1;
            grant_idx_nxt_s    = pick_next_s;
          end else begin
            state_nxt_s        = IDLE;
            grant_onehot_nxt_s = 8'h00;
            grant_valid_nxt_s  = 1'b0;
          end
        end else begin
          // Grant held stable until accepted, whatever req_in/enable do.
          state_nxt_s = GRANT;
        end
      end
      default: begin
        state_nxt_s        = IDLE;
        grant_onehot_nxt_s = 8'h00;
        grant_valid_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any outstanding grant and
  // discards coincident requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      pending_r      <= 8'h00;
      grant_onehot_r <= 8'h00;
      grant_valid_r  <= 1'b0;
      grant_idx_r    <= 3'd0;
      last_ptr_r     <= 3'd7;
      grant_count_r  <= '0;
    end else begin
      state_r        <= state_nxt_s;
      pending_r      <= pending_nxt_s;
      grant_onehot_r <= grant_onehot_nxt_s;
      grant_valid_r  <= grant_valid_nxt_s;
      grant_idx_r    <= grant_idx_nxt_s;
      last_ptr_r     <= last_ptr_nxt_s;
      grant_count_r  <= grant_count_nxt_s;
    end
  end

  assign bus.grant_onehot = grant_onehot_r;
  assign bus.grant_valid  = grant_valid_r;
  assign bus.pending      = pending_r;
  assign bus.grant_count  = grant_count_r;

endmodule
